conv_engine_param: RTL and testbench

- Parametrised 2D convolution engine: next generation of the fixed-size conv core.
- Reads a PIX_W-bit signed image and a K×K signed kernel from single-port read SRAMs, each with 1-cycle read latency.
- Writes one ACC_W-bit result per output pixel to the output SRAM.
- Adds a runtime stride select (1/2), optional ReLU, and a busy flag. Sits between the conv_top start/finish control and the three memories.

---
 rtl/conv_engine_param.sv | 179 +++++++++++++++++
 tb/tb_conv_engine_param.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_engine_param.sv
// Parametrised KxK 2D convolution engine: streams taps from pixel/weight SRAMs,
// accumulates one result per output pixel and writes it to the output SRAM.
module conv_engine_param #(
   parameter int IMG_W  = 5,
   parameter int IMG_H  = 5,
   parameter int K      = 3,
   parameter int PIX_W  = 9,
   parameter int WGT_W  = 8,
   parameter int ACC_W  = 20,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stride2,
   input  logic              relu_en,
   output logic              pixel_req,
   output logic [ADDR_W-1:0] pixel_addr,
   input  logic [PIX_W-1:0]  pixel,
   output logic              weight_req,
   output logic [ADDR_W-1:0] weight_addr,
   input  logic [WGT_W-1:0]  weight,
   output logic              output_req,
   output logic [ADDR_W-1:0] output_addr,
   output logic [ACC_W-1:0]  output_data,
   output logic              busy,
   output logic              finish
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_DRAIN = 3'd2;
   localparam logic [2:0] ST_WRITE = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(K - 1);
   localparam logic [ADDR_W-1:0] OW_S1  = ADDR_W'(IMG_W - K + 1);
   localparam logic [ADDR_W-1:0] OH_S1  = ADDR_W'(IMG_H - K + 1);
   localparam logic [ADDR_W-1:0] OW_S2  = ADDR_W'((IMG_W - K) / 2 + 1);
   localparam logic [ADDR_W-1:0] OH_S2  = ADDR_W'((IMG_H - K) / 2 + 1);

   logic [2:0]              state;
   logic                    s2_q, relu_q;
   logic [ADDR_W-1:0]       kr, kc, orow, ocol;
   logic                    valid_q, tap0_q;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] prod;

   logic [ADDR_W-1:0] out_w, out_h, row_base, col_base;
   logic [ADDR_W-1:0] pa_live, wa_live, oa_live;
   logic [ACC_W-1:0]  od_live;
   logic [ADDR_W-1:0] pa_hold, wa_hold, oa_hold;
   logic [ACC_W-1:0]  od_hold;
   logic              last_tap, last_out;

   always_comb begin
      out_w    = s2_q ? OW_S2 : OW_S1;
      out_h    = s2_q ? OH_S2 : OH_S1;
      row_base = s2_q ? {orow[ADDR_W-2:0], 1'b0} : orow;
      col_base = s2_q ? {ocol[ADDR_W-2:0], 1'b0} : ocol;
      pa_live  = (row_base + kr) * ADDR_W'(IMG_W) + col_base + kc;
      wa_live  = kr * ADDR_W'(K) + kc;
      oa_live  = orow * out_w + ocol;
      od_live  = (relu_q && acc[ACC_W-1]) ? '0 : acc;
      last_tap = (kr == K_LAST) && (kc == K_LAST);
      last_out = (orow == out_h - ADDR_W'(1)) && (ocol == out_w - ADDR_W'(1));
   end

   // Strobes decode straight from state; addresses/data fall back to the last
   // strobed value so they hold while the strobe is low.
   always_comb begin
      pixel_req   = (state == ST_FETCH);
      weight_req  = (state == ST_FETCH);
      output_req  = (state == ST_WRITE);
      busy        = (state != ST_IDLE);
      finish      = (state == ST_DONE);
      pixel_addr  = pixel_req  ? pa_live : pa_hold;
      weight_addr = weight_req ? wa_live : wa_hold;
      output_addr = output_req ? oa_live : oa_hold;
      output_data = output_req ? od_live : od_hold;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= ST_IDLE;
         s2_q   <= 1'b0;
         relu_q <= 1'b0;
         kr     <= '0;
         kc     <= '0;
         orow   <= '0;
         ocol   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  s2_q   <= stride2;
                  relu_q <= relu_en;
                  kr     <= '0;
                  kc     <= '0;
                  orow   <= '0;
                  ocol   <= '0;
                  state  <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (kc == K_LAST) begin
                  kc <= '0;
                  if (kr == K_LAST) begin
                     kr    <= '0;
                     state <= ST_DRAIN;
                  end else begin
                     kr <= kr + ADDR_W'(1);
                  end
               end else begin
                  kc <= kc + ADDR_W'(1);
               end
            end
            ST_DRAIN: state <= ST_WRITE;
            ST_WRITE: begin
               if (last_out) begin
                  state <= ST_DONE;
               end else begin
                  state <= ST_FETCH;
                  if (ocol == out_w - ADDR_W'(1)) begin
                     ocol <= '0;
                     orow <= orow + ADDR_W'(1);
                  end else begin
                     ocol <= ocol + ADDR_W'(1);
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Multiplying in ACC_W bits is exact modulo 2^ACC_W even when ACC_W is
   // narrower than the full product.
   always_comb begin
      prod = ACC_W'($signed(pixel)) * ACC_W'($signed(weight));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         tap0_q  <= 1'b0;
         acc     <= '0;
      end else begin
         valid_q <= (state == ST_FETCH);
         tap0_q  <= (state == ST_FETCH) && (kr == '0) && (kc == '0);
         if (valid_q) begin
            acc <= tap0_q ? prod : acc + prod;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pa_hold <= '0;
         wa_hold <= '0;
         oa_hold <= '0;
         od_hold <= '0;
      end else begin
         if (pixel_req)  pa_hold <= pa_live;
         if (weight_req) wa_hold <= wa_live;
         if (output_req) begin
            oa_hold <= oa_live;
            od_hold <= od_live;
         end
      end
   end

   // synthesis-neutral sanity: geometry must fit the image
   if (K > IMG_W || K > IMG_H) begin : g_bad_geometry
      illegal_kernel_size_for_image u_err ();
   end

endmodule

// File: tb/tb_conv_engine_param.sv
// Self-checking bench for conv_engine_param: table-driven runs against a
// behavioural convolution model, plus reset/start corner sequences.
module tb_conv_engine_param;
   localparam int IMG_W  = 5;
   localparam int IMG_H  = 5;
   localparam int K      = 3;
   localparam int PIX_W  = 9;
   localparam int WGT_W  = 8;
   localparam int ACC_W  = 20;
   localparam int ADDR_W = 10;
   localparam int TAPS   = K * K;

   logic clk = 1'b0, reset = 1'b0, start = 1'b0, stride2 = 1'b0, relu_en = 1'b0;
   logic pixel_req, weight_req, output_req, busy, finish;
   logic [ADDR_W-1:0] pixel_addr, weight_addr, output_addr;
   logic [PIX_W-1:0]  pixel = '0;
   logic [WGT_W-1:0]  weight = '0;
   logic [ACC_W-1:0]  output_data;

   logic start16 = 1'b0;
   logic p_req16, w_req16, o_req16, busy16, fin16;
   logic [ADDR_W-1:0] pa16, wa16, oa16;
   logic [PIX_W-1:0]  pix16 = '0;
   logic [WGT_W-1:0]  wgt16 = '0;
   logic [15:0]       od16;

   conv_engine_param #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .PIX_W(PIX_W),
                       .WGT_W(WGT_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) u_dut (
      .clk(clk), .reset(reset), .start(start), .stride2(stride2), .relu_en(relu_en),
      .pixel_req(pixel_req), .pixel_addr(pixel_addr), .pixel(pixel),
      .weight_req(weight_req), .weight_addr(weight_addr), .weight(weight),
      .output_req(output_req), .output_addr(output_addr), .output_data(output_data),
      .busy(busy), .finish(finish));

   conv_engine_param #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .PIX_W(PIX_W),
                       .WGT_W(WGT_W), .ACC_W(16), .ADDR_W(ADDR_W)) u_dut16 (
      .clk(clk), .reset(reset), .start(start16), .stride2(1'b0), .relu_en(1'b0),
      .pixel_req(p_req16), .pixel_addr(pa16), .pixel(pix16),
      .weight_req(w_req16), .weight_addr(wa16), .weight(wgt16),
      .output_req(o_req16), .output_addr(oa16), .output_data(od16),
      .busy(busy16), .finish(fin16));

   always #5 clk = ~clk;

   int pix_mem [IMG_W*IMG_H];
   int wgt_mem [TAPS];
   int cyc = 0;
   int c0 = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (pixel_req)  pixel <= PIX_W'(pix_mem[pixel_addr]);
      if (weight_req) weight <= WGT_W'(wgt_mem[weight_addr]);
      if (p_req16)    pix16 <= PIX_W'(pix_mem[pa16]);
      if (w_req16)    wgt16 <= WGT_W'(wgt_mem[wa16]);
   end

   int wr_addr[$], wr_cyc[$], pa_q[$], wa_q[$], fin_q[$];
   logic [ACC_W-1:0] wr_data[$];
   logic [15:0] q16[$];
   int busy_cnt, busy_first, busy_last, fin16_cnt;

   always @(negedge clk) begin
      int rel;
      rel = cyc - c0;
      if (output_req) begin
         wr_addr.push_back(int'(output_addr));
         wr_data.push_back(output_data);
         wr_cyc.push_back(rel);
      end
      if (pixel_req) begin
         pa_q.push_back(int'(pixel_addr));
         wa_q.push_back(int'(weight_addr));
      end
      if (finish) fin_q.push_back(rel);
      if (busy) begin
         if (busy_cnt == 0) busy_first = rel;
         busy_last = rel;
         busy_cnt++;
      end
      if (o_req16) q16.push_back(od16);
      if (fin16) fin16_cnt++;
   end

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
      pa_q.delete(); wa_q.delete(); fin_q.delete();
      busy_cnt = 0; busy_first = -1; busy_last = -1;
   endtask

   // pmode: 0 = all +1, 2 = random; wmode: 0 = all +1, 1 = all -1, 2 = random
   task automatic fill_mem(input int pmode, input int wmode);
      foreach (pix_mem[i])
         pix_mem[i] = (pmode == 2) ? int'($urandom_range(0, 511)) - 256 : 1;
      foreach (wgt_mem[i])
         wgt_mem[i] = (wmode == 2) ? int'($urandom_range(0, 255)) - 128 :
                      (wmode == 1) ? -1 : 1;
   endtask

   function automatic logic [ACC_W-1:0] ref_out(input bit s2, input bit re,
                                                input int orow, input int ocol);
      longint sum;
      logic [63:0] bits;
      logic [ACC_W-1:0] w;
      int s;
      s = s2 ? 2 : 1;
      sum = 0;
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++)
            sum += longint'(pix_mem[(orow*s + r)*IMG_W + ocol*s + c]) * wgt_mem[r*K + c];
      bits = sum;
      w = bits[ACC_W-1:0];
      if (re && w[ACC_W-1]) w = '0;
      return w;
   endfunction

   task automatic run_job(input bit s2, input bit re, input int extra_start);
      clear_mon();
      @(negedge clk);
      c0 = cyc; stride2 = s2; relu_en = re; start = 1'b1;
      @(negedge clk);
      start = 1'b0; stride2 = ~s2; relu_en = ~re;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         start = (cyc - c0 == extra_start);
         if (fin_q.size() > 0) break;
      end
      start = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic verify_job(input string tag, input bit s2, input bit re, input int n_out,
                             input int fin_cyc, input bit has_data, input logic [ACC_W-1:0] data);
      int s, ow, oh, idx, nw;
      s = s2 ? 2 : 1;
      ow = (IMG_W - K) / s + 1;
      oh = (IMG_H - K) / s + 1;
      check({tag, ".writes"}, wr_addr.size(), n_out);
      check({tag, ".finish_cnt"}, fin_q.size(), 1);
      if (fin_q.size() > 0) check({tag, ".finish_cyc"}, fin_q[0], fin_cyc);
      check({tag, ".busy_first"}, busy_first, 1);
      check({tag, ".busy_last"}, busy_last, fin_cyc);
      check({tag, ".busy_cnt"}, busy_cnt, fin_cyc);
      nw = (wr_addr.size() < ow*oh) ? wr_addr.size() : ow*oh;
      for (int i = 0; i < nw; i++) begin
         check($sformatf("%s.addr[%0d]", tag, i), wr_addr[i], i);
         check($sformatf("%s.data[%0d]", tag, i), longint'(wr_data[i]),
               longint'(ref_out(s2, re, i / ow, i % ow)));
         check($sformatf("%s.wcyc[%0d]", tag, i), wr_cyc[i], 11 + i*(TAPS + 2));
         if (has_data)
            check($sformatf("%s.const[%0d]", tag, i), longint'(wr_data[i]), longint'(data));
      end
      check({tag, ".reads"}, pa_q.size(), ow*oh*TAPS);
      idx = 0;
      for (int orow = 0; orow < oh; orow++)
         for (int ocol = 0; ocol < ow; ocol++)
            for (int r = 0; r < K; r++)
               for (int c = 0; c < K; c++) begin
                  if (idx < pa_q.size()) begin
                     check($sformatf("%s.pa[%0d]", tag, idx), pa_q[idx],
                           (orow*s + r)*IMG_W + ocol*s + c);
                     check($sformatf("%s.wa[%0d]", tag, idx), wa_q[idx], r*K + c);
                  end
                  idx++;
               end
   endtask

   typedef struct {
      bit               s2;
      bit               re;
      int               pmode;
      int               wmode;
      int               n_out;
      int               fin;
      bit               has_data;
      logic [ACC_W-1:0] data;
   } vec_t;

   vec_t vecs[$];

   initial begin
      vecs.push_back('{1'b0, 1'b0, 0, 0, 9, 100, 1'b1, 20'd9});
      vecs.push_back('{1'b1, 1'b0, 0, 0, 4,  45, 1'b1, 20'd9});
      vecs.push_back('{1'b0, 1'b0, 0, 1, 9, 100, 1'b1, 20'hFFFF7});
      vecs.push_back('{1'b0, 1'b1, 0, 1, 9, 100, 1'b1, 20'h00000});
      vecs.push_back('{1'b0, 1'b0, 2, 2, 9, 100, 1'b0, 20'h0});
      vecs.push_back('{1'b1, 1'b1, 2, 2, 4,  45, 1'b0, 20'h0});
      vecs.push_back('{1'b0, 1'b1, 2, 2, 9, 100, 1'b0, 20'h0});
      vecs.push_back('{1'b1, 1'b0, 2, 2, 4,  45, 1'b0, 20'h0});

      clear_mon();
      fill_mem(0, 0);
      repeat (3) @(negedge clk);
      check("rst.pixel_req", pixel_req, 0);
      check("rst.weight_req", weight_req, 0);
      check("rst.output_req", output_req, 0);
      check("rst.busy", busy, 0);
      check("rst.finish", finish, 0);
      check("rst.pixel_addr", pixel_addr, 0);
      check("rst.output_data", output_data, 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      foreach (vecs[v]) begin
         fill_mem(vecs[v].pmode, vecs[v].wmode);
         run_job(vecs[v].s2, vecs[v].re, -1);
         verify_job($sformatf("vec%0d", v), vecs[v].s2, vecs[v].re, vecs[v].n_out,
                    vecs[v].fin, vecs[v].has_data, vecs[v].data);
      end

      // start re-pulsed mid-run must be ignored
      fill_mem(0, 0);
      run_job(1'b0, 1'b0, 20);
      verify_job("restart", 1'b0, 1'b0, 9, 100, 1'b1, 20'd9);

      // asynchronous reset mid-run aborts at once
      clear_mon();
      @(negedge clk);
      c0 = cyc; stride2 = 1'b0; relu_en = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (cyc - c0 < 30) @(negedge clk);
      check("abort.pre_req", pixel_req, 1);
      reset = 1'b0;
      #1;
      check("abort.pixel_req", pixel_req, 0);
      check("abort.weight_req", weight_req, 0);
      check("abort.output_req", output_req, 0);
      check("abort.busy", busy, 0);
      check("abort.finish", finish, 0);
      check("abort.pixel_addr", pixel_addr, 0);
      check("abort.weight_addr", weight_addr, 0);
      check("abort.output_addr", output_addr, 0);
      check("abort.output_data", output_data, 0);
      clear_mon();
      repeat (5) @(negedge clk);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      check("abort.reads_after", pa_q.size(), 0);
      check("abort.writes_after", wr_addr.size(), 0);
      check("abort.busy_after", busy_cnt, 0);
      run_job(1'b0, 1'b0, -1);
      verify_job("post_abort", 1'b0, 1'b0, 9, 100, 1'b1, 20'd9);

      // 16-bit accumulator wraps without saturation
      foreach (pix_mem[i]) pix_mem[i] = 255;
      foreach (wgt_mem[i]) wgt_mem[i] = 127;
      q16.delete();
      fin16_cnt = 0;
      @(negedge clk);
      start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (fin16_cnt > 0) break;
      end
      repeat (2) @(negedge clk);
      check("wrap.finish_cnt", fin16_cnt, 1);
      check("wrap.writes", q16.size(), 9);
      foreach (q16[i]) check($sformatf("wrap.data[%0d]", i), q16[i], 16'h7289);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
